// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encoding, screen and paddle geometry,
// and the paddle shrink rule.
package pong_pkg;

    localparam int SCREEN_W      = 640;
    localparam int WIDTH_DEFAULT = 150;
    localparam int WIDTH_MIN     = 40;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } match_state_t;

    // Floor-clamped subtraction; the comparison avoids wrapping the 10-bit width.
    function automatic logic [9:0] shrink_width(input logic [9:0] w,
                                                input int step,
                                                input int floor_w);
        if (w >= 10'(floor_w + step))
            return w - 10'(step);
        else
            return 10'(floor_w);
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame_tick countdown; done fires combinationally on the tick that
// exhausts the loaded count.
module pong_frame_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - CW'(1);
    end

    assign done = tick && (count == CW'(1));

endmodule

// File: rtl/match_controller.sv
// Pong rally/match sequencer: scoring, serve timing, paddle shrink, winner.
// Paddle shrink is built only when PADDLE_SHRINK_EN is defined.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIDTH_DEFAULT   = pong_pkg::WIDTH_DEFAULT,
    parameter int WIDTH_MIN       = pong_pkg::WIDTH_MIN,
    parameter int SHRINK_STEP     = 10,
    parameter int HITS_PER_SHRINK = 4,
    parameter int WIN_SCORE       = 7,
    parameter int SERVE_FRAMES    = 60,
    parameter int POINT_FRAMES    = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit1,
    input  logic       hit2,
    input  logic       miss1,
    input  logic       miss2,
    output logic       paddle_rst,
    output logic       game_end,
    output logic       ball_launch,
    output logic       serve_to,
    output logic [9:0] paddle1_width,
    output logic [9:0] paddle2_width,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state
);

    match_state_t st_q, st_n;
    logic [3:0]   s1_q, s1_n, s2_q, s2_n;
    logic         serve_q, serve_n, prst_q, prst_n, launch_q, launch_n, gend_q, gend_n;
    logic         start_q, start_rise;
    logic         tmr_load, tmr_tick, tmr_done;
    logic [7:0]   tmr_val;
    logic [1:0]   hit_ok;
    logic         clr_hits, clr_match;

    assign start_rise = start & ~start_q;
    assign tmr_tick   = frame_tick && (st_q == ST_SERVE || st_q == ST_POINT);

    pong_frame_timer #(.CW(8)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .done     (tmr_done)
    );

    always_comb begin
        st_n      = st_q;
        s1_n      = s1_q;
        s2_n      = s2_q;
        serve_n   = serve_q;
        prst_n    = 1'b0;
        launch_n  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = 8'(SERVE_FRAMES);
        hit_ok    = '0;
        clr_hits  = 1'b0;
        clr_match = 1'b0;
        unique case (st_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    st_n      = ST_SERVE;
                    s1_n      = '0;
                    s2_n      = '0;
                    serve_n   = 1'b0;
                    prst_n    = 1'b1;
                    clr_match = 1'b1;
                    tmr_load  = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tmr_done) begin
                    st_n     = ST_PLAY;
                    launch_n = 1'b1;
                end
            end
            ST_PLAY: begin
                // A miss ends the rally, so a same-cycle hit never counts.
                if (miss1 || miss2) begin
                    st_n     = ST_POINT;
                    tmr_load = 1'b1;
                    tmr_val  = 8'(POINT_FRAMES);
                    if (miss1 && !miss2) begin
                        s2_n    = s2_q + 4'd1;
                        serve_n = 1'b0;
                    end else if (miss2 && !miss1) begin
                        s1_n    = s1_q + 4'd1;
                        serve_n = 1'b1;
                    end
                end else begin
                    hit_ok = {hit2, hit1};
                end
            end
            ST_POINT: begin
                if (tmr_done) begin
                    if (s1_q == 4'(WIN_SCORE) || s2_q == 4'(WIN_SCORE)) begin
                        st_n = ST_OVER;
                    end else begin
                        st_n     = ST_SERVE;
                        prst_n   = 1'b1;
                        clr_hits = 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            default: st_n = ST_IDLE;
        endcase
        gend_n = (st_n == ST_IDLE || st_n == ST_POINT || st_n == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= ST_IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            serve_q  <= 1'b0;
            prst_q   <= 1'b0;
            launch_q <= 1'b0;
            gend_q   <= 1'b1;
            start_q  <= 1'b0;
        end else begin
            st_q     <= st_n;
            s1_q     <= s1_n;
            s2_q     <= s2_n;
            serve_q  <= serve_n;
            prst_q   <= prst_n;
            launch_q <= launch_n;
            gend_q   <= gend_n;
            start_q  <= start;
        end
    end

`ifdef PADDLE_SHRINK_EN
    logic [3:0] hc1_q, hc2_q;
    logic [9:0] w1_q, w2_q;

    always_ff @(posedge clk) begin
        if (reset || clr_match) begin
            hc1_q <= '0;
            hc2_q <= '0;
            w1_q  <= 10'(WIDTH_DEFAULT);
            w2_q  <= 10'(WIDTH_DEFAULT);
        end else if (clr_hits) begin
            hc1_q <= '0;
            hc2_q <= '0;
        end else begin
            if (hit_ok[0]) begin
                if (hc1_q == 4'(HITS_PER_SHRINK - 1)) begin
                    hc1_q <= '0;
                    w1_q  <= shrink_width(w1_q, SHRINK_STEP, WIDTH_MIN);
                end else begin
                    hc1_q <= hc1_q + 4'd1;
                end
            end
            if (hit_ok[1]) begin
                if (hc2_q == 4'(HITS_PER_SHRINK - 1)) begin
                    hc2_q <= '0;
                    w2_q  <= shrink_width(w2_q, SHRINK_STEP, WIDTH_MIN);
                end else begin
                    hc2_q <= hc2_q + 4'd1;
                end
            end
        end
    end

    assign paddle1_width = w1_q;
    assign paddle2_width = w2_q;
`else
    logic unused_shrink;
    assign unused_shrink = ^{hit_ok, clr_hits, clr_match};
    assign paddle1_width = 10'(WIDTH_DEFAULT);
    assign paddle2_width = 10'(WIDTH_DEFAULT);
`endif

    assign state       = st_q;
    assign score1      = s1_q;
    assign score2      = s2_q;
    assign serve_to    = serve_q;
    assign paddle_rst  = prst_q;
    assign ball_launch = launch_q;
    assign game_end    = gend_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed vector table, hand-written match
// sequences and randomized traffic against a behavioural match model.
module tb_match_controller;

    localparam int SF = 60, PF = 90, WS = 7, WD = 150, WM = 40, STEP = 10, HPS = 4;
`ifdef PADDLE_SHRINK_EN
    localparam bit SHR = 1'b1;
`else
    localparam bit SHR = 1'b0;
`endif
    localparam int W140 = SHR ? 140 : WD;
    localparam int W120 = SHR ? 120 : WD;
    localparam int W40  = SHR ? 40  : WD;

    logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
    logic hit1 = 1'b0, hit2 = 1'b0, miss1 = 1'b0, miss2 = 1'b0;
    logic paddle_rst, game_end, ball_launch, serve_to;
    logic [9:0] paddle1_width, paddle2_width;
    logic [3:0] score1, score2;
    logic [2:0] state;

    match_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .hit1(hit1), .hit2(hit2), .miss1(miss1), .miss2(miss2),
        .paddle_rst(paddle_rst), .game_end(game_end), .ball_launch(ball_launch),
        .serve_to(serve_to), .paddle1_width(paddle1_width), .paddle2_width(paddle2_width),
        .score1(score1), .score2(score2), .state(state)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // Match model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over.
    int m_ph, m_fr, m_s1, m_s2, m_w1, m_w2, m_h1, m_h2, m_serve, m_prst, m_launch, m_prev;

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    function automatic int shrunk(input int w);
        return (w - STEP < WM) ? WM : w - STEP;
    endfunction

    task automatic model_step();
        int nph;
        bit rise;
        if (reset) begin
            m_ph = 0; m_fr = 0; m_s1 = 0; m_s2 = 0; m_w1 = WD; m_w2 = WD;
            m_h1 = 0; m_h2 = 0; m_serve = 0; m_prst = 0; m_launch = 0; m_prev = 0;
            return;
        end
        rise = start && (m_prev == 0);
        m_prev = start;
        m_prst = 0; m_launch = 0;
        nph = m_ph;
        case (m_ph)
            0, 4: if (rise) begin
                nph = 1; m_s1 = 0; m_s2 = 0; m_w1 = WD; m_w2 = WD;
                m_h1 = 0; m_h2 = 0; m_serve = 0; m_prst = 1;
            end
            1: if (frame_tick) begin
                m_fr++;
                if (m_fr == SF) begin nph = 2; m_launch = 1; end
            end
            2: if (miss1 || miss2) begin
                nph = 3;
                if (miss1 && !miss2) begin m_s2++; m_serve = 0; end
                else if (miss2 && !miss1) begin m_s1++; m_serve = 1; end
            end else if (SHR) begin
                if (hit1) begin m_h1++; if (m_h1 == HPS) begin m_h1 = 0; m_w1 = shrunk(m_w1); end end
                if (hit2) begin m_h2++; if (m_h2 == HPS) begin m_h2 = 0; m_w2 = shrunk(m_w2); end end
            end
            3: if (frame_tick) begin
                m_fr++;
                if (m_fr == PF) begin
                    if (m_s1 == WS || m_s2 == WS) nph = 4;
                    else begin nph = 1; m_prst = 1; m_h1 = 0; m_h2 = 0; end
                end
            end
            default: nph = 0;
        endcase
        if (nph != m_ph) m_fr = 0;
        m_ph = nph;
    endtask

    task automatic compare_model();
        check("state", state, m_ph);
        check("game_end", game_end, (m_ph == 0 || m_ph == 3 || m_ph == 4) ? 1 : 0);
        check("paddle_rst", paddle_rst, m_prst);
        check("ball_launch", ball_launch, m_launch);
        check("serve_to", serve_to, m_serve);
        check("score1", score1, m_s1);
        check("score2", score2, m_s2);
        check("paddle1_width", paddle1_width, m_w1);
        check("paddle2_width", paddle2_width, m_w2);
    endtask

    task automatic cycle(input bit st, input bit tk, input bit a, input bit b,
                         input bit c, input bit d, input bit rs);
        @(negedge clk);
        start = st; frame_tick = tk; hit1 = a; hit2 = b; miss1 = c; miss2 = d; reset = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        string name;
        bit    st, tk, h1, h2, m1, m2;
        int    reps;
        int    e_state, e_s1, e_s2, e_sv, e_w1, e_w2;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{"start_low",    0,0,0,0,0,0,  2, 0,0,0,0, WD,  WD});
        tbl.push_back('{"start_rise",   1,0,0,0,0,0,  1, 1,0,0,0, WD,  WD});
        tbl.push_back('{"serve59",      1,1,0,0,0,0, 59, 1,0,0,0, WD,  WD});
        tbl.push_back('{"serve60",      1,1,0,0,0,0,  1, 2,0,0,0, WD,  WD});
        tbl.push_back('{"hit1x4",       1,0,1,0,0,0,  4, 2,0,0,0, W140,WD});
        tbl.push_back('{"hit1x44",      1,0,1,0,0,0, 44, 2,0,0,0, W40, WD});
        tbl.push_back('{"tick_in_play", 1,1,0,0,0,0,  5, 2,0,0,0, W40, WD});
        tbl.push_back('{"start_drop",   0,0,0,0,0,0,  1, 2,0,0,0, W40, WD});
        tbl.push_back('{"start_again",  1,0,0,0,0,0,  1, 2,0,0,0, W40, WD});
        tbl.push_back('{"miss1",        1,0,0,0,1,0,  1, 3,0,1,0, W40, WD});
        tbl.push_back('{"point89",      1,1,0,0,0,0, 89, 3,0,1,0, W40, WD});
        tbl.push_back('{"point90",      1,1,0,0,0,0,  1, 1,0,1,0, W40, WD});
        tbl.push_back('{"serve_b",      1,1,0,0,0,0, 60, 2,0,1,0, W40, WD});
        tbl.push_back('{"hit2x3",       1,0,0,1,0,0,  3, 2,0,1,0, W40, WD});
        tbl.push_back('{"miss2_hit2",   1,0,0,1,0,1,  1, 3,1,1,1, W40, WD});
        tbl.push_back('{"point_c",      1,1,0,0,0,0, 90, 1,1,1,1, W40, WD});
        tbl.push_back('{"serve_c",      1,1,0,0,0,0, 60, 2,1,1,1, W40, WD});
        tbl.push_back('{"miss_both",    1,0,0,0,1,1,  1, 3,1,1,1, W40, WD});
        tbl.push_back('{"point_d",      1,1,0,0,0,0, 90, 1,1,1,1, W40, WD});
        tbl.push_back('{"serve_d",      1,1,0,0,0,0, 60, 2,1,1,1, W40, WD});
        tbl.push_back('{"hit2x4",       1,0,0,1,0,0,  4, 2,1,1,1, W40, W140});

        // Reset values
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("rst_state", state, 0);
        check("rst_game_end", game_end, 1);
        check("rst_paddle_rst", paddle_rst, 0);
        check("rst_ball_launch", ball_launch, 0);
        check("rst_serve_to", serve_to, 0);
        check("rst_w1", paddle1_width, WD);
        check("rst_w2", paddle2_width, WD);
        check("rst_scores", {score1, score2}, 0);

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].reps; r++)
                cycle(tbl[k].st, tbl[k].tk, tbl[k].h1, tbl[k].h2, tbl[k].m1, tbl[k].m2, 0);
            check({tbl[k].name, "_state"}, state, tbl[k].e_state);
            check({tbl[k].name, "_score1"}, score1, tbl[k].e_s1);
            check({tbl[k].name, "_score2"}, score2, tbl[k].e_s2);
            check({tbl[k].name, "_serve_to"}, serve_to, tbl[k].e_sv);
            check({tbl[k].name, "_w1"}, paddle1_width, tbl[k].e_w1);
            check({tbl[k].name, "_w2"}, paddle2_width, tbl[k].e_w2);
        end

        // Full match: player 2 wins 7-0
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        ticks(SF);
        for (int k = 0; k < WS; k++) begin
            cycle(1, 0, 0, 0, 1, 0, 0);
            ticks(PF);
            if (k < WS - 1) ticks(SF);
        end
        check("over_state", state, 4);
        check("over_game_end", game_end, 1);
        check("over_score2", score2, 7);
        check("over_score1", score1, 0);
        ticks(5);
        check("over_holds", state, 4);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("rematch_state", state, 1);
        check("rematch_scores", {score1, score2}, 0);
        check("rematch_w1", paddle1_width, WD);
        check("rematch_paddle_rst", paddle_rst, 1);
        check("rematch_game_end", game_end, 0);

        // Reset in the middle of play with a shrunken paddle
        ticks(SF);
        for (int i = 0; i < 12; i++) cycle(1, 0, 1, 0, 0, 0, 0);
        check("midplay_w1", paddle1_width, W120);
        check("midplay_state", state, 2);
        cycle(1, 0, 0, 0, 0, 0, 1);
        check("midrst_state", state, 0);
        check("midrst_w1", paddle1_width, WD);
        check("midrst_game_end", game_end, 1);
        check("midrst_ball_launch", ball_launch, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 16 == 0) ? ~start : start,
                  ($urandom % 2 == 0),
                  ($urandom % 4 == 0), ($urandom % 4 == 0),
                  ($urandom % 40 == 0), ($urandom % 40 == 0),
                  ($urandom % 600 == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
